led_cnt_multi: RTL and testbench

- Multi-channel successor to the single-channel LED counter.
- NUM_CH independent channels. Each has its own programmable power-of-two divider and a pattern mode: off, binary count, rotate or bounce.
- Each channel raises a sticky per-channel interrupt on every pattern wrap and keeps a saturating wrap counter.
- Sits on the fabric clock between the register/config logic and the board LEDs.

---
 rtl/led_cnt_pkg.sv | 22 ++
 rtl/led_cnt_chan.sv | 118 +++++++++++
 rtl/led_cnt_multi.sv | 45 ++++
 tb/tb_led_cnt_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cnt_pkg.sv
// Shared types and helpers for the multi-channel LED pattern counter.
package led_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int INT_CNT_W_DEF = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_cnt_chan.sv
// One LED channel: power-of-two prescaler, pattern generator (off/count/rotate/bounce),
// sticky wrap interrupt and saturating wrap counter.
module led_cnt_chan
    import led_cnt_pkg::*;
#(
    parameter int LED_W     = 4,
    parameter int DIV_W     = 5,
    parameter int INT_CNT_W = INT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [DIV_W-1:0]     div_i,
    input  logic [1:0]           mode_i,
    input  logic                 int_clr_i,
    output logic [LED_W-1:0]     led_o,
    output logic                 int_o,
    output logic [INT_CNT_W-1:0] int_cnt_o
);

    localparam int PRE_W = 2**DIV_W - 1;

    mode_t                mode_q, mode_d;
    dir_t                 dir_q, dir_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [LED_W-1:0]     pat_q, pat_d;
    logic                 int_q, int_d;
    logic [INT_CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0]     pre_lim;
    logic                 tick;
    logic                 ev;

    // 2^d-1 as a right-shifted all-ones mask avoids a 2^31 shift overflow.
    assign pre_lim = {PRE_W{1'b1}} >> (PRE_W - int'(div_q));
    assign tick    = (pre_q == pre_lim);

    always_comb begin
        mode_d = mode_q;
        div_d  = div_q;
        dir_d  = dir_q;
        pat_d  = pat_q;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        ev     = 1'b0;
        if (tick) begin
            case (mode_q)
                MODE_COUNT: begin
                    pat_d = pat_q + 1'b1;
                    ev    = &pat_q;
                end
                MODE_SHIFT: begin
                    pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                    ev    = pat_q[LED_W-1];
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        pat_d = pat_q << 1;
                        if (pat_d[LED_W-1]) dir_d = DIR_DOWN;
                    end else begin
                        pat_d = pat_q >> 1;
                        if (pat_d[0]) begin
                            dir_d = DIR_UP;
                            ev    = 1'b1;
                        end
                    end
                end
                default: pat_d = '0;
            endcase
        end
        // A write replaces the running pattern, so any wrap it would have made is dropped.
        if (wr_en_i) begin
            mode_d = mode_t'(mode_i);
            div_d  = div_i;
            pre_d  = '0;
            dir_d  = DIR_UP;
            ev     = 1'b0;
            pat_d  = (mode_t'(mode_i) == MODE_SHIFT || mode_t'(mode_i) == MODE_BOUNCE)
                     ? LED_W'(1) : '0;
        end
    end

    always_comb begin
        int_d = int_q;
        cnt_d = cnt_q;
        if (ev) begin
            int_d = 1'b1;
            cnt_d = int_clr_i ? INT_CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
        end else if (int_clr_i) begin
            int_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            div_q  <= '0;
            dir_q  <= DIR_UP;
            pre_q  <= '0;
            pat_q  <= '0;
            int_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            div_q  <= div_d;
            dir_q  <= dir_d;
            pre_q  <= pre_d;
            pat_q  <= pat_d;
            int_q  <= int_d;
            cnt_q  <= cnt_d;
        end
    end

    assign led_o     = pat_q;
    assign int_o     = int_q;
    assign int_cnt_o = cnt_q;

endmodule

// File: rtl/led_cnt_multi.sv
// NUM_CH independent LED pattern channels; decodes config writes and packs channel outputs.
module led_cnt_multi
    import led_cnt_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int LED_W     = 4,
    parameter  int DIV_W     = 5,
    parameter  int INT_CNT_W = INT_CNT_W_DEF,
    localparam int CH_W      = clog2_min1(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wren_i,
    input  logic [CH_W-1:0]             wr_ch_i,
    input  logic [DIV_W-1:0]            div_i,
    input  logic [1:0]                  mode_i,
    input  logic [NUM_CH-1:0]           int_clr_i,
    output logic [NUM_CH*LED_W-1:0]     led_o,
    output logic [NUM_CH-1:0]           int_o,
    output logic [NUM_CH*INT_CNT_W-1:0] int_cnt_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr_en;
        // Channel indices beyond NUM_CH match no instance, so such writes vanish.
        assign wr_en = wren_i && (wr_ch_i == CH_W'(c));

        led_cnt_chan #(
            .LED_W     (LED_W),
            .DIV_W     (DIV_W),
            .INT_CNT_W (INT_CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en),
            .div_i     (div_i),
            .mode_i    (mode_i),
            .int_clr_i (int_clr_i[c]),
            .led_o     (led_o[c*LED_W +: LED_W]),
            .int_o     (int_o[c]),
            .int_cnt_o (int_cnt_o[c*INT_CNT_W +: INT_CNT_W])
        );
    end

endmodule

// File: tb/tb_led_cnt_multi.sv
// Bench for led_cnt_multi: behavioural scoreboard on every cycle plus hand-derived vector tables.
module tb_led_cnt_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren_i = 1'b0;
    logic [1:0]  wr_ch_i = '0;
    logic [4:0]  div_i = '0;
    logic [1:0]  mode_i = '0;
    logic [3:0]  int_clr_i = '0;
    logic [15:0] led_o;
    logic [3:0]  int_o;
    logic [31:0] int_cnt_o;

    led_cnt_multi #(.NUM_CH(4), .LED_W(4), .DIV_W(5), .INT_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wren_i(wren_i), .wr_ch_i(wr_ch_i), .div_i(div_i),
        .mode_i(mode_i), .int_clr_i(int_clr_i), .led_o(led_o), .int_o(int_o),
        .int_cnt_o(int_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic [3:0]  irq;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        bit       we;
        int       ch;
        int       md;
        bit [3:0] clr;
        int       chk;
        int       led;
        int       irq;
        int       cnt;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model keeps a position index per channel instead of a pattern register.
    int m_mode[4], m_div[4], m_since[4], m_pos[4], m_int[4], m_cnt[4];
    int bnc[6] = '{1, 2, 4, 8, 4, 2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0; m_div[c] = 0; m_since[c] = 0;
            m_pos[c] = 0; m_int[c] = 0; m_cnt[c] = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            int l;
            case (m_mode[c])
                1:       l = m_pos[c];
                2:       l = 1 << m_pos[c];
                3:       l = bnc[m_pos[c]];
                default: l = 0;
            endcase
            e.led[c*4 +: 4] = l[3:0];
            e.irq[c]        = (m_int[c] != 0);
            e.cnt[c*8 +: 8] = m_cnt[c][7:0];
        end
        return e;
    endfunction

    task automatic model_edge(input bit we, input int ch, input int dv, input int md,
                              input bit [3:0] clr);
        for (int c = 0; c < 4; c++) begin
            bit ev = 1'b0;
            if (we && ch == c) begin
                m_mode[c] = md; m_div[c] = dv; m_since[c] = 0; m_pos[c] = 0;
            end else begin
                m_since[c]++;
                if (m_since[c] == (1 << m_div[c])) begin
                    m_since[c] = 0;
                    if (m_mode[c] != 0) begin
                        m_pos[c] = (m_pos[c] + 1) % ((m_mode[c] == 1) ? 16 :
                                                     (m_mode[c] == 2) ? 4 : 6);
                        ev = (m_pos[c] == 0);
                    end
                end
            end
            if (ev) begin
                m_int[c] = 1;
                m_cnt[c] = clr[c] ? 1 : ((m_cnt[c] < 255) ? m_cnt[c] + 1 : 255);
            end else if (clr[c]) begin
                m_int[c] = 0; m_cnt[c] = 0;
            end
        end
    endtask

    task automatic step(input bit we, input int ch, input int dv, input int md,
                        input bit [3:0] clr);
        exp_t e;
        wren_i = we; wr_ch_i = ch[1:0]; div_i = dv[4:0]; mode_i = md[1:0]; int_clr_i = clr;
        model_edge(we, ch, dv, md, clr);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("scoreboard", {12'd0, led_o, int_o, int_cnt_o}, {12'd0, e});
        end
        wren_i = 1'b0; int_clr_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'b0);
    endtask

    function automatic vec_t mkv(input bit we, input int ch, input int md, input bit [3:0] clr,
                                 input int chk, input int led, input int irq, input int cnt);
        vec_t v;
        v.we = we; v.ch = ch; v.md = md; v.clr = clr;
        v.chk = chk; v.led = led; v.irq = irq; v.cnt = cnt;
        return v;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        logic [12:0] act, exp;
        step(v.we, v.ch, 0, v.md, v.clr);
        act = {led_o[v.chk*4 +: 4], int_o[v.chk], int_cnt_o[v.chk*8 +: 8]};
        exp = {v.led[3:0], v.irq[0], v.cnt[7:0]};
        check(name, 64'(act), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t shift_tab[13];
        vec_t bounce_tab[13];

        shift_tab[0]  = mkv(1, 1, 2, 4'b0000, 1, 1, 0, 0);
        shift_tab[1]  = mkv(0, 0, 0, 4'b0000, 1, 2, 0, 0);
        shift_tab[2]  = mkv(0, 0, 0, 4'b0000, 1, 4, 0, 0);
        shift_tab[3]  = mkv(0, 0, 0, 4'b0000, 1, 8, 0, 0);
        shift_tab[4]  = mkv(0, 0, 0, 4'b0000, 1, 1, 1, 1);
        shift_tab[5]  = mkv(0, 0, 0, 4'b0000, 1, 2, 1, 1);
        shift_tab[6]  = mkv(0, 0, 0, 4'b0000, 1, 4, 1, 1);
        shift_tab[7]  = mkv(0, 0, 0, 4'b0000, 1, 8, 1, 1);
        shift_tab[8]  = mkv(0, 0, 0, 4'b0010, 1, 1, 1, 1);
        shift_tab[9]  = mkv(0, 0, 0, 4'b0000, 1, 2, 1, 1);
        shift_tab[10] = mkv(0, 0, 0, 4'b0010, 1, 4, 0, 0);
        shift_tab[11] = mkv(0, 0, 0, 4'b0000, 1, 8, 0, 0);
        shift_tab[12] = mkv(0, 0, 0, 4'b0000, 1, 1, 1, 1);

        bounce_tab[0]  = mkv(1, 2, 3, 4'b0000, 2, 1, 0, 0);
        bounce_tab[1]  = mkv(0, 0, 0, 4'b0000, 2, 2, 0, 0);
        bounce_tab[2]  = mkv(0, 0, 0, 4'b0000, 2, 4, 0, 0);
        bounce_tab[3]  = mkv(0, 0, 0, 4'b0000, 2, 8, 0, 0);
        bounce_tab[4]  = mkv(0, 0, 0, 4'b0000, 2, 4, 0, 0);
        bounce_tab[5]  = mkv(0, 0, 0, 4'b0000, 2, 2, 0, 0);
        bounce_tab[6]  = mkv(0, 0, 0, 4'b0000, 2, 1, 1, 1);
        bounce_tab[7]  = mkv(0, 0, 0, 4'b0000, 2, 2, 1, 1);
        bounce_tab[8]  = mkv(0, 0, 0, 4'b0000, 2, 4, 1, 1);
        bounce_tab[9]  = mkv(0, 0, 0, 4'b0000, 2, 8, 1, 1);
        bounce_tab[10] = mkv(0, 0, 0, 4'b0000, 2, 4, 1, 1);
        bounce_tab[11] = mkv(0, 0, 0, 4'b0000, 2, 2, 1, 1);
        bounce_tab[12] = mkv(0, 0, 0, 4'b0000, 2, 1, 1, 2);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", {12'd0, led_o, int_o, int_cnt_o}, 64'd0);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 13; i++) run_vec("shift_tab", shift_tab[i]);
        for (int i = 0; i < 13; i++) run_vec("bounce_tab", bounce_tab[i]);

        // COUNT div=1 on ch0: one step every two edges, wrap at edge 32.
        step(1, 0, 1, 1, 4'b0);
        check("count_init", 64'(led_o[3:0]), 64'd0);
        for (int k = 1; k <= 32; k++) begin
            step(0, 0, 0, 0, 4'b0);
            check("count_seq", 64'(led_o[3:0]), 64'((k / 2) % 16));
        end
        check("count_wrap", 64'({int_o[0], int_cnt_o[7:0]}), 64'({1'b1, 8'd1}));
        idle(18);
        check("count_at9", 64'(led_o[3:0]), 64'd9);

        step(1, 0, 2, 1, 4'b0);
        check("rewrite_led", 64'(led_o[3:0]), 64'd0);
        check("rewrite_cnt", 64'({int_o[0], int_cnt_o[7:0]}), 64'({1'b1, 8'd1}));
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 4'b0);
            check("rewrite_hold", 64'(led_o[3:0]), 64'd0);
        end
        step(0, 0, 0, 0, 4'b0);
        check("rewrite_first", 64'(led_o[3:0]), 64'd1);

        step(1, 3, 0, 1, 4'b0);
        idle(5);
        check("ch3_count", 64'(led_o[15:12]), 64'd5);
        step(1, 3, 0, 0, 4'b0);
        check("ch3_off", 64'(led_o[15:12]), 64'd0);

        // Saturation: clear ch1, then 1200 single-cycle rotates give 300 wraps.
        step(0, 0, 0, 0, 4'b0010);
        idle(1200);
        check("sat_cnt", 64'({int_o[1], int_cnt_o[15:8]}), 64'({1'b1, 8'd255}));

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", {12'd0, led_o, int_o, int_cnt_o}, 64'd0);
        model_reset();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", {12'd0, led_o, int_o, int_cnt_o}, 64'd0);
        end
        rst = 1'b0;
        idle(6);
        check("rst_after", {12'd0, led_o, int_o, int_cnt_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
